mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage of the five-stage RISC-V core. It consumes the EX/ME pipeline register outputs and runs a request/acknowledge transaction on the data-memory bus for loads and stores. It formats store data and byte enables, and sign- or zero-extends load data. It stalls the front of the pipeline while a transaction is outstanding and registers results into the ME/WB boundary for write-back.

## Interface
Parameters:
- TIMEOUT, 255: maximum REQ cycles waiting for dmem_ack before abort; 0 disables timeout.
- TO_W, 8: timeout counter width; TIMEOUT must fit in TO_W bits.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; one clock; asynchronous, active-high.
- alu_result_in  in  32  effective address / ALU result from EX/ME.
- write_data_in  in  32  store source data.
- pcPlus4_in  in  32  PC+4 of the instruction.
- rd_in  in  5  destination register.
- reg_write_in  in  1  register write enable.
- result_sel_in  in  2  write-back mux select, passed through.
- mem_read_in  in  1  load request.
- mem_write_en_in  in  1  store request.
- mem_sign_in  in  1  1 = sign-extend load, 0 = zero-extend.
- mem_length_in  in  2  00 byte, 01 half, 10/11 word.
- dmem_req  out  1  bus request, registered.
- dmem_we  out  1  1 = write, registered.
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}), registered.
- dmem_be  out  4  byte enables, registered.
- dmem_wdata  out  32  lane-replicated store data, registered.
- dmem_ack  in  1  one-cycle acknowledge; rdata valid with it.
- dmem_rdata  in  32  read data.
- mem_stall  out  1  combinational; holds EX/ME and all earlier stages.
- load_data_out, alu_result_out, pcPlus4_out  out  32  ME/WB fields.
- rd_out  out  5; reg_write_out  out  1; result_sel_out  out  2  ME/WB fields.
- bus_err_out  out  1  transaction aborted by timeout.
- misalign_out  out  1  misaligned access (see Configuration).

## Operation
- Access present: mem_read_in | mem_write_en_in. When both are set, the access is a write.
- FSM states: IDLE and REQ.
  - IDLE with access: latch dmem_addr, dmem_we, dmem_be, dmem_wdata and the format controls (mem_sign, mem_length, addr[1:0]). Go to REQ.
  - REQ: dmem_req=1 and is held with stable address/data until ack.
  - REQ with ack: go to IDLE.
  - REQ with counter==TIMEOUT and no ack (TIMEOUT≠0): go to IDLE.
- mem_stall = (IDLE & access) | (REQ & ~ack & ~timeout_hit).
- Store formatting:
  - byte: be = 1<<addr[1:0], wdata = {4{wd[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{wd[15:0]}}.
  - word: be = 1111, wdata = wd.
  - Loads drive be = 1111.
- Load formatting from dmem_rdata:
  - byte: lane addr[1:0].
  - half: lane addr[1].
  - word: as-is.
  - Byte/half are extended per mem_sign.
- ME/WB register, updated every edge:
  - mem_stall=1: loads a bubble (reg_write_out=0, rd_out=0, bus_err_out=0, misalign_out=0); data fields hold.
  - Otherwise: captures the inputs. For a completed load, load_data_out = formatted rdata.
  - Timeout abort: load_data_out=0, reg_write_out=0, bus_err_out=1.
- Ack outside REQ is ignored.

## Timing
- All outputs reset to 0; state resets to IDLE, timeout counter to 0.
- Non-memory instruction: no stall; ME/WB valid on the next edge.
- Memory access, ack after k REQ cycles (k≥1): mem_stall high for k cycles (the IDLE cycle plus k−1 REQ cycles); ME/WB loads on the ack edge.
  - Minimum total is 2 cycles.
- Back-to-back accesses: the next access enters IDLE→REQ immediately after ack, with one idle-bus cycle between requests.
- Timeout counter increments each REQ cycle without ack and clears on leaving REQ.
- Reset mid-REQ: dmem_req drops asynchronously and the outstanding transaction is abandoned.

## Configuration
- MISALIGN_TRAP_EN defined:
  - Misaligned accesses are detected: half with addr[0]=1, or word with addr[1:0]≠00.
  - A misaligned access issues no request and causes no stall.
  - ME/WB loads with misalign_out=1 and reg_write_out=0.
- Undefined:
  - misalign_out is tied 0.
  - Offending low address bits are ignored: half uses addr[1] only; word uses addr[31:2].

## Test plan
- SB addr 0x0000_1003, data 0x0000_00A5 → REQ cycle shows dmem_addr 0x1000, be 1000, wdata 0xA5A5A5A5, we=1.
- LB addr 0x2001, rdata 0x1234_80FF, ack at first REQ cycle → load_data_out 0xFFFF_FF80; LBU → 0x0000_0080; mem_stall exactly 1 cycle.
- LH addr 0x2002, rdata 0x8001_7FFF, signed → 0xFFFF_8001; LW ack delayed 3 REQ cycles → mem_stall 3 cycles, req held with stable address.
- TIMEOUT=4, no ack → dmem_req high 4 cycles, then bus_err_out=1, reg_write_out=0, load_data_out=0; the next access proceeds normally.
- Async rst asserted mid-REQ → dmem_req, mem_stall and all outputs go to 0 before the next edge; after release, a new access starts cleanly.
- LW addr 0x3002:
  - with MISALIGN_TRAP_EN → no dmem_req, misalign_out=1, no stall;
  - without → dmem_addr 0x3000, be 1111.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage -- memory-access stage of the five-stage RISC-V core.
//
// Takes the EX/ME register fields and runs a request/acknowledge transaction
// on the data-memory bus for loads and stores. Store data is lane-replicated
// and byte enables are derived from the access size and low address bits.
// Load data is lane-selected and sign- or zero-extended. The front of the
// pipeline is stalled while a transaction is outstanding. Results are
// registered into the ME/WB boundary.
//
// Parameters:
//   TIMEOUT  REQ cycles allowed without dmem_ack before abort (0 = no timeout)
//   TO_W     timeout counter width
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   *_in                     EX/ME register fields
//   dmem_req/we/addr/be/wdata  registered data-memory request
//   dmem_ack, dmem_rdata     memory response (rdata valid with ack)
//   mem_stall                combinational hold for EX/ME and earlier stages
//   *_out                    ME/WB register fields
//   bus_err_out              transaction aborted by timeout
//   misalign_out             misaligned access trapped
//
// Optional feature: define MISALIGN_TRAP_EN to detect misaligned half/word
// accesses (no bus request, flagged in ME/WB). Without it misalign_out is 0
// and the offending low address bits are ignored.

module mem_access_stage #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] write_data_in,
  input  logic [31:0] pcPlus4_in,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  input  logic [1:0]  result_sel_in,
  input  logic        mem_read_in,
  input  logic        mem_write_en_in,
  input  logic        mem_sign_in,
  input  logic [1:0]  mem_length_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] load_data_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] pcPlus4_out,
  output logic [4:0]  rd_out,
  output logic        reg_write_out,
  output logic [1:0]  result_sel_out,
  output logic        bus_err_out,
  output logic        misalign_out
);

  typedef enum logic {S_IDLE, S_REQ} state_e;

  // The counter holds the REQ cycles already spent without ack, so the
  // TIMEOUT-th REQ cycle is the last one before the abort.
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
  localparam logic            TO_EN   = (TIMEOUT != 0);

  state_e           state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             dmem_req_q, dmem_req_d;
  logic             dmem_we_q, dmem_we_d;
  logic [31:0]      dmem_addr_q, dmem_addr_d;
  logic [3:0]       dmem_be_q, dmem_be_d;
  logic [31:0]      dmem_wdata_q, dmem_wdata_d;
  logic             sign_q, sign_d;
  logic [1:0]       len_q, len_d;
  logic [1:0]       lo_q, lo_d;
  logic [31:0]      load_data_q, load_data_d;
  logic [31:0]      alu_result_q, alu_result_d;
  logic [31:0]      pc_plus4_q, pc_plus4_d;
  logic [4:0]       rd_q, rd_d;
  logic             reg_write_q, reg_write_d;
  logic [1:0]       result_sel_q, result_sel_d;
  logic             bus_err_q, bus_err_d;
  logic             misalign_q, misalign_d;

  logic access, misalign, start, ack_hit, timeout_hit;

  function automatic logic [3:0] store_be(input logic [1:0] len, input logic [1:0] lo);
    case (len)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] len, input logic [31:0] wd);
    case (len)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [1:0] len, input logic [1:0] lo,
                                           input logic sgn, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'b00:   b = rdata[7:0];
      2'b01:   b = rdata[15:8];
      2'b10:   b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (len)
      2'b00:   return {{24{sgn & b[7]}}, b};
      2'b01:   return {{16{sgn & h[15]}}, h};
      default: return rdata;
    endcase
  endfunction

  always_comb begin
    access   = mem_read_in | mem_write_en_in;
    misalign = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misalign = (state_q == S_IDLE) & access &
               (((mem_length_in == 2'b01) & alu_result_in[0]) |
                (mem_length_in[1] & (alu_result_in[1:0] != 2'b00)));
`endif
    start       = (state_q == S_IDLE) & access & ~misalign;
    ack_hit     = (state_q == S_REQ) & dmem_ack;
    timeout_hit = TO_EN & (state_q == S_REQ) & ~dmem_ack & (to_cnt_q == TO_LAST);
    // Gated by rst so the stall drops as soon as reset asserts.
    mem_stall   = ~rst & (start | ((state_q == S_REQ) & ~dmem_ack & ~timeout_hit));
  end

  always_comb begin
    state_d      = state_q;
    to_cnt_d     = to_cnt_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    sign_d       = sign_q;
    len_d        = len_q;
    lo_d         = lo_q;
    load_data_d  = load_data_q;
    alu_result_d = alu_result_q;
    pc_plus4_d   = pc_plus4_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    result_sel_d = result_sel_q;
    bus_err_d    = bus_err_q;
    misalign_d   = misalign_q;

    // Bus side: latch the formatted request once, hold it through REQ.
    if (start) begin
      state_d      = S_REQ;
      to_cnt_d     = '0;
      dmem_req_d   = 1'b1;
      dmem_we_d    = mem_write_en_in;
      dmem_addr_d  = {alu_result_in[31:2], 2'b00};
      dmem_be_d    = mem_write_en_in ? store_be(mem_length_in, alu_result_in[1:0]) : 4'b1111;
      dmem_wdata_d = store_wdata(mem_length_in, write_data_in);
      sign_d       = mem_sign_in;
      len_d        = mem_length_in;
      lo_d         = alu_result_in[1:0];
    end else if (ack_hit || timeout_hit) begin
      state_d    = S_IDLE;
      to_cnt_d   = '0;
      dmem_req_d = 1'b0;
    end else if (state_q == S_REQ) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    // ME/WB side: bubble while stalled, otherwise capture the instruction.
    if (mem_stall) begin
      reg_write_d = 1'b0;
      rd_d        = 5'd0;
      bus_err_d   = 1'b0;
      misalign_d  = 1'b0;
    end else begin
      alu_result_d = alu_result_in;
      pc_plus4_d   = pcPlus4_in;
      rd_d         = rd_in;
      reg_write_d  = reg_write_in;
      result_sel_d = result_sel_in;
      bus_err_d    = 1'b0;
      misalign_d   = 1'b0;
      if (ack_hit && !dmem_we_q) begin
        load_data_d = load_fmt(len_q, lo_q, sign_q, dmem_rdata);
      end
      if (timeout_hit) begin
        load_data_d = 32'd0;
        reg_write_d = 1'b0;
        bus_err_d   = 1'b1;
      end
      if (misalign) begin
        load_data_d = 32'd0;
        reg_write_d = 1'b0;
        misalign_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      to_cnt_q     <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'd0;
      dmem_be_q    <= 4'd0;
      dmem_wdata_q <= 32'd0;
      sign_q       <= 1'b0;
      len_q        <= 2'd0;
      lo_q         <= 2'd0;
      load_data_q  <= 32'd0;
      alu_result_q <= 32'd0;
      pc_plus4_q   <= 32'd0;
      rd_q         <= 5'd0;
      reg_write_q  <= 1'b0;
      result_sel_q <= 2'd0;
      bus_err_q    <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
      sign_q       <= sign_d;
      len_q        <= len_d;
      lo_q         <= lo_d;
      load_data_q  <= load_data_d;
      alu_result_q <= alu_result_d;
      pc_plus4_q   <= pc_plus4_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      result_sel_q <= result_sel_d;
      bus_err_q    <= bus_err_d;
      misalign_q   <= misalign_d;
    end
  end

  assign dmem_req       = dmem_req_q;
  assign dmem_we        = dmem_we_q;
  assign dmem_addr      = dmem_addr_q;
  assign dmem_be        = dmem_be_q;
  assign dmem_wdata     = dmem_wdata_q;
  assign load_data_out  = load_data_q;
  assign alu_result_out = alu_result_q;
  assign pcPlus4_out    = pc_plus4_q;
  assign rd_out         = rd_q;
  assign reg_write_out  = reg_write_q;
  assign result_sel_out = result_sel_q;
  assign bus_err_out    = bus_err_q;
  assign misalign_out   = misalign_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage (TIMEOUT = 4). Honours the
// MISALIGN_TRAP_EN build option for the misaligned-word case.

module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_in, write_data_in, pcPlus4_in;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic [1:0]  result_sel_in;
  logic        mem_read_in, mem_write_en_in, mem_sign_in;
  logic [1:0]  mem_length_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [31:0] load_data_out, alu_result_out, pcPlus4_out;
  logic [4:0]  rd_out;
  logic        reg_write_out;
  logic [1:0]  result_sel_out;
  logic        bus_err_out, misalign_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .alu_result_in(alu_result_in), .write_data_in(write_data_in),
    .pcPlus4_in(pcPlus4_in), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .result_sel_in(result_sel_in), .mem_read_in(mem_read_in),
    .mem_write_en_in(mem_write_en_in), .mem_sign_in(mem_sign_in),
    .mem_length_in(mem_length_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall),
    .load_data_out(load_data_out), .alu_result_out(alu_result_out),
    .pcPlus4_out(pcPlus4_out), .rd_out(rd_out), .reg_write_out(reg_write_out),
    .result_sel_out(result_sel_out), .bus_err_out(bus_err_out),
    .misalign_out(misalign_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    alu_result_in   = 32'd0;
    write_data_in   = 32'd0;
    pcPlus4_in      = 32'd0;
    rd_in           = 5'd0;
    reg_write_in    = 1'b0;
    result_sel_in   = 2'd0;
    mem_read_in     = 1'b0;
    mem_write_en_in = 1'b0;
    mem_sign_in     = 1'b0;
    mem_length_in   = 2'd0;
    dmem_ack        = 1'b0;
    dmem_rdata      = 32'd0;
  endtask

  // Called #1 after a rising edge. Holds the instruction in EX/ME until the
  // stage stops stalling, acks on the k-th REQ cycle (k=0: never), and
  // returns at #1 after the capturing edge.
  task automatic run_instr(input logic rd_en, input logic wr_en, input logic sgn,
                           input logic [1:0] len, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd,
                           input logic rw, input int k, input logic [31:0] rdata,
                           output int stalls, output int req_hi, output logic stable,
                           output logic [31:0] f_addr, output logic [3:0] f_be,
                           output logic [31:0] f_wdata, output logic f_we);
    int  reqc;
    logic done;
    alu_result_in   = addr;
    write_data_in   = wd;
    pcPlus4_in      = addr + 32'd4;
    rd_in           = rd;
    reg_write_in    = rw;
    result_sel_in   = 2'd1;
    mem_read_in     = rd_en;
    mem_write_en_in = wr_en;
    mem_sign_in     = sgn;
    mem_length_in   = len;
    stalls = 0; req_hi = 0; reqc = 0; stable = 1'b1; done = 1'b0;
    f_addr = '0; f_be = '0; f_wdata = '0; f_we = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (dmem_req) reqc++;
      dmem_ack   = dmem_req && (reqc == k);
      dmem_rdata = rdata;
      @(negedge clk);
      if (mem_stall) stalls++;
      if (dmem_req) begin
        if (req_hi == 0) begin
          f_addr = dmem_addr; f_be = dmem_be; f_wdata = dmem_wdata; f_we = dmem_we;
        end else if (dmem_addr !== f_addr || dmem_wdata !== f_wdata) begin
          stable = 1'b0;
        end
        req_hi++;
      end
      done = !mem_stall;
      @(posedge clk); #1;
      if (done) break;
    end
    check("instr_completes", {31'd0, done}, 32'd1);
    clear_inputs();
  endtask

  int          st, rh;
  logic        stb, fwe;
  logic [31:0] fa, fwd;
  logic [3:0]  fbe;

  initial begin
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_load", load_data_out, 32'd0);
    check("rst_regwr", {31'd0, reg_write_out}, 32'd0);
    check("rst_buserr", {31'd0, bus_err_out}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // SB 0x1003 <- 0xA5
    run_instr(1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_1003, 32'h0000_00A5, 5'd0, 1'b0,
              1, 32'd0, st, rh, stb, fa, fbe, fwd, fwe);
    check("sb_addr", fa, 32'h0000_1000);
    check("sb_be", {28'd0, fbe}, 32'h8);
    check("sb_wdata", fwd, 32'hA5A5_A5A5);
    check("sb_we", {31'd0, fwe}, 32'd1);
    check("sb_stall", st, 32'd1);
    check("sb_req_after", {31'd0, dmem_req}, 32'd0);

    // SH 0x2002 <- 0x1234BEEF
    run_instr(1'b0, 1'b1, 1'b0, 2'b01, 32'h0000_2002, 32'h1234_BEEF, 5'd0, 1'b0,
              1, 32'd0, st, rh, stb, fa, fbe, fwd, fwe);
    check("sh_be", {28'd0, fbe}, 32'hC);
    check("sh_wdata", fwd, 32'hBEEF_BEEF);

    // LB 0x2001, rdata 0x123480FF
    run_instr(1'b1, 1'b0, 1'b1, 2'b00, 32'h0000_2001, 32'd0, 5'd5, 1'b1,
              1, 32'h1234_80FF, st, rh, stb, fa, fbe, fwd, fwe);
    check("lb_data", load_data_out, 32'hFFFF_FF80);
    check("lb_stall", st, 32'd1);
    check("lb_be", {28'd0, fbe}, 32'hF);
    check("lb_we", {31'd0, fwe}, 32'd0);
    check("lb_regwr", {31'd0, reg_write_out}, 32'd1);
    check("lb_rd", {27'd0, rd_out}, 32'd5);

    // LBU same address
    run_instr(1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_2001, 32'd0, 5'd6, 1'b1,
              1, 32'h1234_80FF, st, rh, stb, fa, fbe, fwd, fwe);
    check("lbu_data", load_data_out, 32'h0000_0080);
    check("lbu_stall", st, 32'd1);

    // LH 0x2002 signed, rdata 0x80017FFF
    run_instr(1'b1, 1'b0, 1'b1, 2'b01, 32'h0000_2002, 32'd0, 5'd7, 1'b1,
              1, 32'h8001_7FFF, st, rh, stb, fa, fbe, fwd, fwe);
    check("lh_data", load_data_out, 32'hFFFF_8001);

    // LHU 0x2000, rdata 0x7FFF8001
    run_instr(1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_2000, 32'd0, 5'd7, 1'b1,
              1, 32'h7FFF_8001, st, rh, stb, fa, fbe, fwd, fwe);
    check("lhu_data", load_data_out, 32'h0000_8001);

    // LW 0x2004 with ack on the third REQ cycle
    run_instr(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_2004, 32'd0, 5'd8, 1'b1,
              3, 32'hDEAD_BEEF, st, rh, stb, fa, fbe, fwd, fwe);
    check("lw3_stall", st, 32'd3);
    check("lw3_reqhi", rh, 32'd3);
    check("lw3_stable", {31'd0, stb}, 32'd1);
    check("lw3_addr", fa, 32'h0000_2004);
    check("lw3_data", load_data_out, 32'hDEAD_BEEF);

    // Non-memory instruction, with a stray ack that must be ignored
    alu_result_in = 32'h55; pcPlus4_in = 32'h104; rd_in = 5'd9;
    reg_write_in = 1'b1; result_sel_in = 2'd2; dmem_ack = 1'b1;
    @(negedge clk);
    check("alu_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    check("alu_req", {31'd0, dmem_req}, 32'd0);
    check("alu_result", alu_result_out, 32'h55);
    check("alu_pc4", pcPlus4_out, 32'h104);
    check("alu_rd", {27'd0, rd_out}, 32'd9);
    check("alu_regwr", {31'd0, reg_write_out}, 32'd1);
    check("alu_rsel", {30'd0, result_sel_out}, 32'd2);
    clear_inputs();

    // Timeout: no ack ever
    run_instr(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_4000, 32'd0, 5'd10, 1'b1,
              0, 32'h1111_1111, st, rh, stb, fa, fbe, fwd, fwe);
    check("to_reqhi", rh, 32'd4);
    check("to_stall", st, 32'd4);
    check("to_buserr", {31'd0, bus_err_out}, 32'd1);
    check("to_regwr", {31'd0, reg_write_out}, 32'd0);
    check("to_load", load_data_out, 32'd0);

    // Next access after timeout
    run_instr(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_4008, 32'd0, 5'd11, 1'b1,
              1, 32'h0BAD_F00D, st, rh, stb, fa, fbe, fwd, fwe);
    check("post_to_data", load_data_out, 32'h0BAD_F00D);
    check("post_to_buserr", {31'd0, bus_err_out}, 32'd0);
    check("post_to_regwr", {31'd0, reg_write_out}, 32'd1);

    // Asynchronous reset in the middle of REQ
    alu_result_in = 32'h0000_5000; mem_read_in = 1'b1; mem_length_in = 2'b10;
    rd_in = 5'd12; reg_write_in = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_req_up", {31'd0, dmem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_req", {31'd0, dmem_req}, 32'd0);
    check("arst_stall", {31'd0, mem_stall}, 32'd0);
    check("arst_load", load_data_out, 32'd0);
    check("arst_alu", alu_result_out, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_inputs();
    run_instr(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_5000, 32'd0, 5'd12, 1'b1,
              2, 32'hCAFE_0001, st, rh, stb, fa, fbe, fwd, fwe);
    check("post_rst_stall", st, 32'd2);
    check("post_rst_data", load_data_out, 32'hCAFE_0001);

    // Misaligned word load
    run_instr(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_3002, 32'd0, 5'd13, 1'b1,
              1, 32'h5555_AAAA, st, rh, stb, fa, fbe, fwd, fwe);
`ifdef MISALIGN_TRAP_EN
    check("mis_reqhi", rh, 32'd0);
    check("mis_stall", st, 32'd0);
    check("mis_flag", {31'd0, misalign_out}, 32'd1);
    check("mis_regwr", {31'd0, reg_write_out}, 32'd0);
`else
    check("mis_addr", fa, 32'h0000_3000);
    check("mis_be", {28'd0, fbe}, 32'hF);
    check("mis_flag", {31'd0, misalign_out}, 32'd0);
    check("mis_data", load_data_out, 32'h5555_AAAA);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
